// File: rtl/instruction_fetch_pkg.sv
// Shared opcode, field and state definitions
// for the instruction fetch stage.
package instruction_fetch_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  localparam int OP_HI  = 7;
  localparam int OP_LO  = 6;
  localparam int OFF_HI = 5;
  localparam int OFF_LO = 0;
  localparam int OFF_W  = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_HALT  = 2'b10
  } state_t;

endpackage

// File: rtl/instruction_fetch_pc_next.sv
// Next-pc computation: sequential step or
// relative jump, plus program-range test.
module pc_next
  import instruction_fetch_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int PROG_LEN = 6
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [7:0]        instruction,
  output logic [ADDR_W-1:0] next_pc,
  output logic              out_of_range
);

  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(PROG_LEN);

  logic [OFF_W-1:0]  off;
  logic [ADDR_W-1:0] step;

  assign off = instruction[OFF_HI:OFF_LO];

  always_comb begin
    step = ADDR_W'(1);
    if (instruction[OP_HI:OP_LO] == OP_JMP)
      step = ADDR_W'(1)
           + {{(ADDR_W-OFF_W){off[OFF_W-1]}}, off};
  end

  // Wraps modulo 2^ADDR_W by construction
  assign next_pc      = pc + step;
  assign out_of_range = next_pc >= LIMIT;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: walks instruction memory and
// hands words downstream over valid/ready.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int PROG_LEN = 6,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [ADDR_W-1:0] ReadAddress,
  input  logic [7:0]        instruction,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc;
  logic              oob;
  logic              load;
  logic              xfer;

  pc_next #(
    .ADDR_W   (ADDR_W),
    .PROG_LEN (PROG_LEN)
  ) u_pc_next (
    .pc           (pc),
    .instruction  (instruction),
    .next_pc      (next_pc),
    .out_of_range (oob)
  );

  assign ReadAddress = pc;
  assign xfer = out_valid && out_ready;
  assign load = (state == S_FETCH) && run
             && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      out_valid <= 1'b0;
      out_instr <= 8'h00;
      out_pc    <= '0;
      halted    <= 1'b0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_instr <= instruction;
        out_pc    <= pc;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          pc <= '0;
          if (run) state <= S_FETCH;
        end
        S_FETCH: begin
          if (load) begin
            pc <= next_pc;
            if (oob) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
          end
        end
        S_HALT: begin
          // Restart needs run to drop first
          if (!run) begin
            state  <= S_IDLE;
            pc     <= '0;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          pc     <= '0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed and random checks of instruction_fetch
// against a program-walk reference model.
module tb_instruction_fetch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [7:0] ReadAddress;
  logic [7:0] instruction;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_instr;
  logic [7:0] out_pc;
  logic       halted;

  logic [7:0] mem [256];
  int total = 0;
  int bad = 0;

  bit [15:0] exp_q [$];
  bit        exp_halt;

  always #5 clk = ~clk;

  assign instruction = mem[ReadAddress];

  instruction_fetch #(
    .PROG_LEN (6),
    .ADDR_W   (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .ReadAddress (ReadAddress),
    .instruction (instruction),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .halted      (halted)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic load_prog(input logic [47:0] p);
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 6; i++) mem[i] = p[8*(5-i) +: 8];
  endtask

  task automatic do_reset();
    run = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Walk the program by its architectural rules
  task automatic walk(input int maxn);
    int pc;
    int npc;
    int off;
    logic [7:0] ins;
    exp_q.delete();
    exp_halt = 1'b0;
    pc = 0;
    while (exp_q.size() < maxn) begin
      ins = mem[pc];
      exp_q.push_back({pc[7:0], ins});
      off = int'(ins[5:0]);
      if (off >= 32) off = off - 64;
      if (ins[7:6] == 2'b11) npc = (pc + 1 + off) & 255;
      else npc = (pc + 1) & 255;
      if (npc >= 6) begin
        exp_halt = 1'b1;
        break;
      end
      pc = npc;
    end
  endtask

  // Drain transfers until halt or maxn, compare in order
  task automatic run_check(input string tag,
                           input int maxn,
                           input bit rnd);
    int idx = 0;
    int bubbles = 0;
    walk(maxn);
    for (int c = 0; c < 1000; c++) begin
      if ((halted && !out_valid) || idx == maxn) break;
      out_ready = rnd ? 1'($urandom % 2) : 1'b1;
      if (!rnd && idx > 0 && !out_valid) bubbles++;
      if (out_valid && out_ready) begin
        if (idx < exp_q.size()) begin
          chk({tag, "_pc"}, out_pc, exp_q[idx][15:8]);
          chk({tag, "_ins"}, out_instr, exp_q[idx][7:0]);
        end
        idx++;
      end
      @(negedge clk);
    end
    chk({tag, "_count"}, idx, exp_q.size());
    if (exp_halt) chk({tag, "_halted"}, halted, 1);
    if (!rnd) chk({tag, "_bubbles"}, bubbles, 0);
  endtask

  initial begin
    int n;

    load_prog(48'h71_4D_74_B7_05_C2);
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_instr", out_instr, 8'h00);
    chk("rst_pc", out_pc, 0);
    chk("rst_addr", ReadAddress, 0);
    chk("rst_halted", halted, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Straight-line program and two-edge latency
    run = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("lat_edge1", out_valid, 0);
    @(negedge clk);
    chk("lat_edge2", out_valid, 1);
    chk("lat_pc", out_pc, 0);
    run_check("seq", 20, 1'b0);
    repeat (3) @(negedge clk);
    chk("hold_halted", halted, 1);
    chk("hold_valid", out_valid, 0);

    // Forward jump skips word 3
    load_prog(48'h71_4D_C1_B7_05_C2);
    do_reset();
    run = 1'b1;
    @(negedge clk);
    run_check("jmp", 20, 1'b0);

    // Stall on word 1
    load_prog(48'h71_4D_74_B7_05_C2);
    do_reset();
    run = 1'b1;
    out_ready = 1'b1;
    n = 0;
    while (!(out_valid && out_pc == 8'd1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall_wait", n < 20, 1);
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_instr", out_instr, 8'h4D);
      chk("stall_pc", out_pc, 1);
      chk("stall_addr", ReadAddress, 2);
      chk("stall_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_next", out_pc, 2);
    chk("stall_nvalid", out_valid, 1);

    // Self-loop never halts
    load_prog(48'h71_FF_74_B7_05_C2);
    do_reset();
    run = 1'b1;
    @(negedge clk);
    run_check("loop", 12, 1'b0);
    chk("loop_halted", halted, 0);

    // Out-of-range jump at 0, then restart
    load_prog(48'hDF_4D_74_B7_05_C2);
    do_reset();
    run = 1'b1;
    @(negedge clk);
    run_check("oob", 5, 1'b0);
    run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rs_halted", halted, 0);
    chk("rs_addr", ReadAddress, 0);
    run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rs_valid", out_valid, 1);
    chk("rs_pc", out_pc, 0);

    // Asynchronous reset during a stall
    load_prog(48'h71_4D_74_B7_05_C2);
    do_reset();
    run = 1'b1;
    repeat (4) @(negedge clk);
    chk("ar_pre", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_instr", out_instr, 8'h00);
    chk("ar_pc", out_pc, 0);
    chk("ar_addr", ReadAddress, 0);
    chk("ar_halted", halted, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Random programs with random backpressure
    for (int t = 0; t < 6; t++) begin
      logic [47:0] p;
      p = {$urandom, $urandom};
      load_prog(p);
      do_reset();
      run = 1'b1;
      @(negedge clk);
      run_check("rand", 30, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter PROG_LEN, default 6: number of valid instruction-memory words; addresses 0..PROG_LEN-1 are legal.
REQ-002 Parameter ADDR_W, default 8: width of the program counter and ReadAddress.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous and active-low.
REQ-005 run  input  1  level; 1 enables fetching; a 0->1 transition while halted restarts the program from address 0.
REQ-006 ReadAddress  output  ADDR_W  combinational address to the instruction memory; always equals pc.
REQ-007 instruction  input  8  combinational memory data for ReadAddress, sampled in the same cycle.
REQ-008 out_valid  output  1  output register holds an undelivered instruction.
REQ-009 out_ready  input  1  downstream decoder accepts; a transfer occurs on a cycle with out_valid=1 and out_ready=1.
REQ-010 out_instr  output  8  registered instruction word.
REQ-011 out_pc  output  ADDR_W  address out_instr was fetched from.
REQ-012 halted  output  1  1 while in state HALT.

Function
REQ-013 States: IDLE, FETCH, HALT; two-bit encoding.
REQ-014 IDLE: pc=0, no fetch; run=1 at a clock edge moves to FETCH.
REQ-015 Load condition in FETCH: run=1 and (out_valid=0 or out_ready=1); only then does the block sample instruction, load out_instr/out_pc, set out_valid=1 and update pc, all on the same edge.
REQ-016 No load but transfer (out_valid=1, out_ready=1): out_valid clears; pc holds.
REQ-017 Neither: out_instr, out_pc, out_valid, pc all hold (stall); out_instr stays stable while out_valid=1 and out_ready=0.
REQ-018 Next pc: if instruction[7:6]=2'b11 (jump), pc+1+sext(instruction[5:0]) modulo 2^ADDR_W; otherwise pc+1.
REQ-019 If the next pc is >= PROG_LEN (unsigned, wrap included), the current instruction is still loaded; the state goes to HALT and pc holds the out-of-range value.
REQ-020 A jump whose target equals its own address (offset -1) is legal and loops indefinitely.
REQ-021 FETCH with run=0: no new load; pending out_valid still drains via out_ready; pc holds; stays in FETCH.
REQ-022 HALT: no loads; pending output drains normally; halted=1.
REQ-023 HALT to IDLE happens when run=0 (pc cleared to 0); a later run=1 then restarts at address 0; a held-high run never restarts.
REQ-024 Throughput: with out_ready tied to 1 and run=1, one instruction per cycle.
REQ-025 Latency: first out_valid is 2 edges after run rises (IDLE->FETCH, then load).

Reset
REQ-026 rst_n=0 asynchronously forces state=IDLE, pc=0, out_valid=0, out_instr=8'h00, out_pc=0, halted=0.
REQ-027 Reset mid-stall or mid-program discards the pending output with no transfer; fetching resumes only per REQ-014.

Structure
REQ-028 Shared package holds: the opcode constants (ADD 2'b00, LW 2'b01, SW 2'b10, JMP 2'b11), the instruction field positions, and the state encoding.
REQ-029 Single module; one optional sub-module, pc_next, holds the combinational REQ-018 logic.

Verification
REQ-030 Program {71,4D,74,B7,05,C2} (hex), PROG_LEN=6, out_ready=1, run=1: out_pc sequence 0,1,2,3,4,5; halted=1 after word 5 loads.
REQ-031 Word 2 = 8'hC1 (jump +1), PROG_LEN=6: out_pc sequence 0,1,2,4,5, then HALT.
REQ-032 out_ready=0 for 3 cycles while out_instr=8'h4D: out_instr, out_pc=1 and ReadAddress=2 stay constant; the next transfer presents pc=2.
REQ-033 Word 1 = 8'hFF (offset -1): out_pc repeats 1 indefinitely; halted stays 0.
REQ-034 Jump 8'hDF at pc=0 (target 0x20 >= 6): one output out_pc=0, then halted=1; run 1->0->1 restarts at pc=0.
REQ-035 rst_n pulsed low while out_valid=1 and out_ready=0: all outputs return to reset values immediately, with no transfer.
